// File: rtl/game_pkg.sv
// Shared types and geometry for the detection path: frame size, box struct,
// and the extractor FSM states.
package game_pkg;

  localparam int COORD_W  = 11;
  localparam int NUM_OBJ  = 2;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int MIN_PIX  = 16;
  localparam int CNT_W    = 16;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   count_t;

  typedef struct packed {
    coord_t l;
    coord_t r;
    coord_t u;
    coord_t d;
  } bbox_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    COMMIT
  } bbx_state_e;

  localparam coord_t H_LIMIT  = coord_t'(H_ACTIVE);
  localparam coord_t V_LIMIT  = coord_t'(V_ACTIVE);
  localparam count_t MIN_CNT  = count_t'(MIN_PIX);
  localparam count_t CNT_SAT  = {CNT_W{1'b1}};

  // An empty box: min fields at the top of the range so the first hit wins.
  localparam bbox_t BBOX_CLEARED = '{
    l: {COORD_W{1'b1}},
    r: {COORD_W{1'b0}},
    u: {COORD_W{1'b1}},
    d: {COORD_W{1'b0}}
  };

  function automatic coord_t coord_min(input coord_t a, input coord_t b);
    return (b < a) ? b : a;
  endfunction

  function automatic coord_t coord_max(input coord_t a, input coord_t b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/bbox_accum.sv
// Per-object bounding-box accumulator. Outputs are look-ahead values that
// already include the pixel presented this cycle.
module bbox_accum
  import game_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   clr_i,
  input  logic   en_i,
  input  coord_t x_i,
  input  coord_t y_i,
  output bbox_t  box_o,
  output count_t count_o
);

  bbox_t  box_q,   box_d;
  count_t count_q, count_d;

  // Clear first, then fold in the pixel, so a hit on the clearing cycle
  // becomes the first member of the new frame.
  always_comb begin
    box_d   = clr_i ? BBOX_CLEARED : box_q;
    count_d = clr_i ? '0 : count_q;
    if (en_i) begin
      box_d.l = coord_min(box_d.l, x_i);
      box_d.r = coord_max(box_d.r, x_i);
      box_d.u = coord_min(box_d.u, y_i);
      box_d.d = coord_max(box_d.d, y_i);
      if (count_d != CNT_SAT) begin
        count_d = count_d + count_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      box_q   <= BBOX_CLEARED;
      count_q <= '0;
    end else begin
      box_q   <= box_d;
      count_q <= count_d;
    end
  end

  assign box_o   = box_d;
  assign count_o = count_d;

endmodule

// File: rtl/bbox_extractor.sv
// Scans per-pixel object masks over a frame and commits one bounding box per
// object at frame end, pulsing predict_valid for the commit cycle.
module bbox_extractor
  import game_pkg::*;
(
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_frame_start,
  input  logic                             i_frame_end,
  input  logic                             i_pix_valid,
  input  logic [COORD_W-1:0]               i_x,
  input  logic [COORD_W-1:0]               i_y,
  input  logic [NUM_OBJ-1:0]               i_hit,
  output logic [NUM_OBJ-1:0][COORD_W-1:0]  left,
  output logic [NUM_OBJ-1:0][COORD_W-1:0]  right,
  output logic [NUM_OBJ-1:0][COORD_W-1:0]  up,
  output logic [NUM_OBJ-1:0][COORD_W-1:0]  down,
  output logic [NUM_OBJ-1:0]               o_found,
  output logic                             predict_valid
);

  bbx_state_e          state_q;
  logic                predict_valid_q;
  logic [NUM_OBJ-1:0]  found_q;
  bbox_t               box_q   [NUM_OBJ];

  bbox_t               acc_box [NUM_OBJ];
  count_t              acc_cnt [NUM_OBJ];

  logic                pix_in_range;
  logic                accepting;
  logic [NUM_OBJ-1:0]  acc_en;

  assign pix_in_range = i_pix_valid && (i_x < H_LIMIT) && (i_y < V_LIMIT);

  // A frame start in any state opens a new frame on this very cycle.
  assign accepting = i_frame_start || (state_q == ACCUM);

  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
    assign acc_en[gi] = accepting && pix_in_range && i_hit[gi];

    bbox_accum u_accum (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .clr_i   (i_frame_start),
      .en_i    (acc_en[gi]),
      .x_i     (i_x),
      .y_i     (i_y),
      .box_o   (acc_box[gi]),
      .count_o (acc_cnt[gi])
    );

    assign left[gi]  = box_q[gi].l;
    assign right[gi] = box_q[gi].r;
    assign up[gi]    = box_q[gi].u;
    assign down[gi]  = box_q[gi].d;
  end

  // Commit samples the look-ahead accumulators so a pixel arriving with
  // i_frame_end is part of the committed box.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= IDLE;
      predict_valid_q <= 1'b0;
      found_q         <= '0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        box_q[k] <= '0;
      end
    end else begin
      predict_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_frame_start) begin
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (i_frame_start) begin
            state_q <= ACCUM;
          end else if (i_frame_end) begin
            state_q         <= COMMIT;
            predict_valid_q <= 1'b1;
            for (int k = 0; k < NUM_OBJ; k++) begin
              if (acc_cnt[k] >= MIN_CNT) begin
                box_q[k]   <= acc_box[k];
                found_q[k] <= 1'b1;
              end else begin
                found_q[k] <= 1'b0;
              end
            end
          end
        end
        COMMIT: begin
          state_q <= i_frame_start ? ACCUM : IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_found       = found_q;
  assign predict_valid = predict_valid_q;

endmodule

// File: tb/tb_bbox_extractor.sv
// Directed bench for bbox_extractor: reset, single box, threshold, edge
// events, abort/back-to-back frames, overlapping objects, mid-frame reset.
module tb_bbox_extractor;
  import game_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            fs, fe, pv;
  logic [COORD_W-1:0]              px, py;
  logic [NUM_OBJ-1:0]              hit;
  logic [NUM_OBJ-1:0][COORD_W-1:0] left, right, up, down;
  logic [NUM_OBJ-1:0]              found;
  logic                            predict_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bbox_extractor dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_start (fs),
    .i_frame_end   (fe),
    .i_pix_valid   (pv),
    .i_x           (px),
    .i_y           (py),
    .i_hit         (hit),
    .left          (left),
    .right         (right),
    .up            (up),
    .down          (down),
    .o_found       (found),
    .predict_valid (predict_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_box(input string tag, input int k, input int l, input int r,
                         input int u, input int d);
    chk({tag, "_left"},  32'(left[k]),  32'(l));
    chk({tag, "_right"}, 32'(right[k]), 32'(r));
    chk({tag, "_up"},    32'(up[k]),    32'(u));
    chk({tag, "_down"},  32'(down[k]),  32'(d));
    $display("%s obj%0d box l=%0d r=%0d u=%0d d=%0d found=%b pv=%b",
             tag, k, left[k], right[k], up[k], down[k], found, predict_valid);
  endtask

  task automatic pix(input int x, input int y, input logic [1:0] h);
    pv  = 1'b1;
    px  = coord_t'(x);
    py  = coord_t'(y);
    hit = h;
    step();
    pv  = 1'b0;
    hit = '0;
  endtask

  task automatic start_frame();
    fs = 1'b1;
    step();
    fs = 1'b0;
  endtask

  task automatic end_frame(input logic with_pix, input int x, input int y, input logic [1:0] h);
    fe  = 1'b1;
    pv  = with_pix;
    px  = coord_t'(x);
    py  = coord_t'(y);
    hit = h;
    step();
    fe  = 1'b0;
    pv  = 1'b0;
    hit = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    fs = 1'b0; fe = 1'b0; pv = 1'b0; px = '0; py = '0; hit = '0;
    repeat (3) step();

    // Reset state
    for (int k = 0; k < NUM_OBJ; k++) chk_box("rst", k, 0, 0, 0, 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_pv", 32'(predict_valid), 0);
    rst_n = 1'b1;
    step();

    // Reset asserted mid-frame, then a stray frame end from IDLE
    start_frame();
    for (int i = 0; i < 20; i++) pix(100 + i, 50, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_inrst_pv", 32'(predict_valid), 0);
    chk("t1_inrst_found", 32'(found), 0);
    step();
    rst_n = 1'b1;
    step();
    end_frame(1'b0, 0, 0, 2'b00);
    chk("t1_no_pulse", 32'(predict_valid), 0);
    chk("t1_found", 32'(found), 0);
    chk_box("t1", 0, 0, 0, 0, 0);

    // Single object, 20x20 square
    start_frame();
    for (int yy = 50; yy < 70; yy++)
      for (int xx = 100; xx < 120; xx++) pix(xx, yy, 2'b01);
    end_frame(1'b0, 0, 0, 2'b00);
    chk("t2_pv", 32'(predict_valid), 1);
    chk("t2_found", 32'(found), 32'b01);
    chk_box("t2", 0, 100, 119, 50, 69);
    chk_box("t2", 1, 0, 0, 0, 0);
    step();
    chk("t2_pv_one_cycle", 32'(predict_valid), 0);
    chk("t2_found_hold", 32'(found), 32'b01);

    // Threshold: 15 hits rejected, 16 accepted
    start_frame();
    for (int i = 0; i < 15; i++) pix(300, 300, 2'b01);
    end_frame(1'b0, 0, 0, 2'b00);
    chk("t3a_pv", 32'(predict_valid), 1);
    chk("t3a_found", 32'(found), 32'b00);
    chk_box("t3a", 0, 100, 119, 50, 69);
    step();
    start_frame();
    for (int i = 0; i < 16; i++) pix(300, 300, 2'b01);
    end_frame(1'b0, 0, 0, 2'b00);
    chk("t3b_found", 32'(found), 32'b01);
    chk_box("t3b", 0, 300, 300, 300, 300);
    step();

    // Edge events: hit with frame end counted, out-of-range pixels ignored
    start_frame();
    for (int i = 0; i < 15; i++) pix(300, 300, 2'b01);
    pix(800, 0, 2'b01);
    pix(10, 600, 2'b01);
    end_frame(1'b1, 5, 7, 2'b01);
    chk("t4_pv", 32'(predict_valid), 1);
    chk("t4_found", 32'(found), 32'b01);
    chk_box("t4", 0, 5, 300, 7, 300);
    step();

    // Abort mid-frame
    start_frame();
    for (int i = 0; i < 20; i++) pix(0, 0, 2'b01);
    start_frame();
    chk("t5_abort_no_pv", 32'(predict_valid), 0);
    for (int i = 0; i < 16; i++) pix(200, 210, 2'b01);
    end_frame(1'b0, 0, 0, 2'b00);
    chk("t5a_found", 32'(found), 32'b01);
    chk_box("t5a", 0, 200, 200, 210, 210);
    step();

    // Back-to-back: frame start (with a pixel) during COMMIT
    start_frame();
    for (int i = 0; i < 16; i++) pix(400, 410, 2'b01);
    end_frame(1'b0, 0, 0, 2'b00);
    chk("t5b_pv", 32'(predict_valid), 1);
    chk_box("t5b", 0, 400, 400, 410, 410);
    fs = 1'b1;
    pix(420, 430, 2'b01);
    fs = 1'b0;
    chk("t5c_pv_drop", 32'(predict_valid), 0);
    for (int i = 0; i < 15; i++) pix(420, 430, 2'b01);
    end_frame(1'b0, 0, 0, 2'b00);
    chk("t5c_pv", 32'(predict_valid), 1);
    chk("t5c_found", 32'(found), 32'b01);
    chk_box("t5c", 0, 420, 420, 430, 430);
    step();

    // Both objects on the same square
    start_frame();
    for (int yy = 10; yy <= 40; yy++)
      for (int xx = 10; xx <= 40; xx++) pix(xx, yy, 2'b11);
    end_frame(1'b0, 0, 0, 2'b00);
    chk("t6_found", 32'(found), 32'b11);
    chk_box("t6", 0, 10, 40, 10, 40);
    chk_box("t6", 1, 10, 40, 10, 40);
    step();

    // Reset with committed boxes present clears everything immediately
    start_frame();
    for (int i = 0; i < 4; i++) pix(60, 60, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk_box("t7", 0, 0, 0, 0, 0);
    chk_box("t7", 1, 0, 0, 0, 0);
    chk("t7_found", 32'(found), 0);
    chk("t7_pv", 32'(predict_valid), 0);
    step();
    rst_n = 1'b1;
    step();
    end_frame(1'b0, 0, 0, 2'b00);
    chk("t7_no_pulse", 32'(predict_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
